// File: rtl/z80_bus_mem_model.sv
// Byte-array memory/IO responder for the tv80s bus: configurable wait states, mapped I/O page,
// bench backdoor port, and an in-order write-trace FIFO with a sticky overflow flag.
module z80_bus_mem_model #(
  parameter int          ADDR_W      = 16,
  parameter logic [7:0]  IO_PAGE     = 8'h10,
  parameter int          WAIT_CYCLES = 0,
  parameter int          TRACE_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_di,
  output logic              wait_n,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [ADDR_W+8:0] trace_data,
  output logic              trace_ovf
);

  localparam int EW = (ADDR_W > 16) ? ADDR_W : 16;
  localparam int PW = $clog2(TRACE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  logic [7:0]        mem [2**ADDR_W];
  logic [ADDR_W+8:0] fifo [TRACE_DEPTH];

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        done, done_next;
  logic        cpu_we;
  logic        strb;
  logic [EW-1:0]     io_addr;
  logic [ADDR_W-1:0] eff;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, push, pop;

  assign strb    = (!mreq_n || !iorq_n) && (!rd_n || !wr_n);
  assign io_addr = EW'({IO_PAGE, A[7:0]});
  assign eff     = iorq_n ? A : io_addr[ADDR_W-1:0];
  assign wait_n  = (state != WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = done;
    cpu_we     = 1'b0;
    case (state)
      IDLE: begin
        done_next = 1'b0;
        if (strb) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_next = ACK;
          end
        end
      end
      WAIT: begin
        if (!strb)             state_next = IDLE;
        else if (cnt == 4'd0)  state_next = ACK;
        else                   cnt_next   = cnt - 4'd1;
      end
      ACK: begin
        if (!strb) begin
          state_next = IDLE;
        end else if (!wr_n && !done) begin
          // one write per bus cycle even if wr_n stays low for several clocks
          cpu_we    = 1'b1;
          done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // CPU write is issued after the backdoor so it wins on an address collision
  always_ff @(posedge clk) begin
    if (bd_we)  mem[bd_addr] <= bd_wdata;
    if (cpu_we) mem[eff]     <= cpu_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_di   <= 8'h00;
      bd_rdata <= 8'h00;
    end else begin
      cpu_di   <= mem[eff];
      bd_rdata <= mem[bd_addr];
    end
  end

  assign full        = (count == (PW+1)'(TRACE_DEPTH));
  assign trace_valid = (count != '0);
  assign push        = cpu_we && !full;
  assign pop         = trace_valid && trace_ready;
  assign trace_data  = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {!iorq_n, eff, cpu_dout};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      trace_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (cpu_we && full) trace_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_z80_bus_mem_model.sv
// Bench for z80_bus_mem_model: directed bus cycles plus a randomized mix, checked against
// an associative-array memory model and a trace queue.
module tb_z80_bus_mem_model;
  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout, cpu_di;
  logic        wait_n;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_wdata, bd_rdata;
  logic        trace_valid, trace_ready, trace_ovf;
  logic [24:0] trace_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [int];
  logic [24:0] tq [$];
  logic        ref_ovf;
  logic [15:0] known [$];

  z80_bus_mem_model #(.ADDR_W(16), .IO_PAGE(8'h10), .WAIT_CYCLES(2), .TRACE_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di), .wait_n(wait_n),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input bit io, input logic [15:0] eff, input logic [7:0] d);
    ref_mem[eff] = d;
    known.push_back(eff);
    if (tq.size() < 4) tq.push_back({io, eff, d});
    else ref_ovf = 1'b1;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bd_chk(input string tag, input logic [15:0] a);
    bd_addr = a;
    @(negedge clk);
    chk(tag, bd_rdata, ref_mem[a]);
  endtask

  task automatic pop_chk();
    chk("trace_valid", trace_valid, 1);
    chk("trace_data", trace_data, tq[0]);
    chk("trace_ovf", trace_ovf, ref_ovf);
    void'(tq.pop_front());
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0;
  endtask

  task automatic drain();
    while (tq.size() > 0) pop_chk();
    chk("trace_empty", trace_valid, 0);
  endtask

  // Full CPU bus cycle; starts and ends on a falling edge
  task automatic bus(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d,
                     input bit collide);
    int lows;
    bit done;
    logic [15:0] eff;
    eff = io ? {8'h10, a[7:0]} : a;
    A = a; cpu_dout = d;
    mreq_n = io; iorq_n = !io; rd_n = wr; wr_n = !wr;
    lows = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (i == 0 && !wr) chk("cpu_di", cpu_di, ref_mem[eff]);
      if (!wait_n) lows++;
      else if (i > 0) done = 1;
    end
    chk("wait_released", done, 1);
    chk("wait_low_clks", lows, 2);
    if (collide) begin
      bd_we = 1'b1; bd_addr = a; bd_wdata = 8'h11; ref_mem[eff] = 8'h11;
    end
    @(posedge clk); #1;
    bd_we = 1'b0;
    @(negedge clk);
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    if (wr) model_write(io, eff, d);
  endtask

  initial begin
    logic [15:0] a, e;
    logic [7:0]  d;
    bit          io;
    reset = 1'b1;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    A = '0; cpu_dout = '0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; trace_ready = 1'b0;
    ref_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_cpu_di", cpu_di, 0);
    chk("rst_bd_rdata", bd_rdata, 0);
    chk("rst_trace_valid", trace_valid, 0);
    chk("rst_trace_ovf", trace_ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    bd_write(16'h2bd6, 8'hd3);
    bd_chk("bd_readback", 16'h2bd6);
    chk("trace_idle_empty", trace_valid, 0);

    bus(0, 1, 16'h2bd6, 8'ha1, 0);
    bd_chk("mem_write", 16'h2bd6);
    chk("mem_trace_entry", trace_data, {1'b0, 16'h2bd6, 8'ha1});
    drain();

    bd_write(16'h0045, 8'h77);
    bus(1, 1, 16'h5c45, 8'h5c, 0);
    bd_chk("io_write", 16'h1045);
    bd_chk("io_low_untouched", 16'h0045);
    drain();

    bus(0, 1, 16'h3000, 8'h22, 1);
    bd_chk("collide_cpu_wins", 16'h3000);
    drain();

    bus(0, 0, 16'h2bd6, 8'h00, 0);
    bus(1, 0, 16'hee45, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      if (known.size() == 0 || $urandom_range(0, 1) == 0) begin
        io = ($urandom_range(0, 3) == 0);
        a = 16'($urandom); d = 8'($urandom);
        bus(io, 1, a, d, 0);
      end else begin
        e = known[$urandom_range(0, known.size() - 1)];
        if (e[15:8] == 8'h10 && $urandom_range(0, 1) == 1)
          bus(1, 0, {8'($urandom), e[7:0]}, 8'h00, 0);
        else
          bus(0, 0, e, 8'h00, 0);
      end
      if (tq.size() >= 3) drain();
    end
    drain();
    for (int n = 0; n < 4; n++) bd_chk("rand_mem", known[$urandom_range(0, known.size() - 1)]);

    for (int n = 0; n < 5; n++) bus(0, 1, 16'h5000 + 16'(n), 8'(8'h60 + n), 0);
    chk("ovf_set", trace_ovf, 1);
    drain();
    chk("ovf_sticky", trace_ovf, 1);
    bd_chk("ovf_dropped_still_written", 16'h5004);

    bd_write(16'h4000, 8'h55);
    bus(0, 1, 16'h6000, 8'h66, 0);
    A = 16'h4000; cpu_dout = 8'hee; mreq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_waiting", wait_n, 0);
    reset = 1'b1;
    #1;
    chk("reset_wait_n", wait_n, 1);
    chk("reset_fifo_empty", trace_valid, 0);
    chk("reset_ovf_clear", trace_ovf, 0);
    @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
    reset = 1'b0;
    tq.delete(); ref_ovf = 1'b0;
    @(negedge clk);
    bd_chk("reset_no_write", 16'h4000);
    bd_chk("reset_prior_data", 16'h6000);
    chk("reset_trace_still_empty", trace_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z80_bus_mem_model.md
Name: z80_bus_mem_model

Overview:
- Parametrised, clocked memory/IO responder for the tv80s CPU bus in CPU-level benches.
- Replaces the ad-hoc per-test memory arrays with one reusable block.
- Adds configurable wait-state insertion, a mapped I/O page, a bench-side backdoor load port, and a write-trace FIFO so benches can check every CPU write in order.
- Sits directly on the cpu A/dout/di/strobe nets; the bench drives the backdoor and drains the trace.

Parameters:
- ADDR_W, 16: CPU address width; the array holds 2**ADDR_W bytes.
- IO_PAGE, 8'h10: upper address byte for I/O. I/O location is {IO_PAGE, A[7:0]}, zero-extended/truncated to ADDR_W.
- WAIT_CYCLES, 0: wait_n-low clocks inserted per bus cycle, 0..15.
- TRACE_DEPTH, 16: write-trace FIFO entries, power of 2, at least 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mreq_n  in  1  CPU memory request.
- iorq_n  in  1  CPU I/O request.
- rd_n  in  1  CPU read strobe.
- wr_n  in  1  CPU write strobe.
- A  in  ADDR_W  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_di  out  8  read data to CPU.
- wait_n  out  1  wait request to CPU.
- bd_we  in  1  backdoor write enable.
- bd_addr  in  ADDR_W  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data, registered.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  bench pops the head.
- trace_data  out  ADDR_W+9  {is_io, addr, data} of the oldest write.
- trace_ovf  out  1  sticky: one or more writes were dropped.

Behaviour:
- Reset:
  - Outputs: wait_n=1, cpu_di=8'h00, bd_rdata=8'h00, trace_valid=0, trace_ovf=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Array contents are not touched. Reset mid-cycle abandons the cycle and records no trace entry.
- Strobe: strb = (!mreq_n | !iorq_n) & (!rd_n | !wr_n). Refresh cycles (mreq_n low, rd_n and wr_n high) are not strobes.
- Effective address: eff = iorq_n==0 ? {IO_PAGE, A[7:0]} : A.
- cpu_di: registered every clock from mem[eff]. Valid 1 clk after A/iorq_n are stable, independent of FSM state.
- FSM:
  - IDLE, strb=1: if WAIT_CYCLES>0, go to WAIT, load cnt=WAIT_CYCLES-1, drive wait_n=0 from the next clock. If WAIT_CYCLES=0, go straight to ACK.
  - WAIT: wait_n=0. Decrement cnt each clock; at cnt=0 go to ACK.
  - ACK: wait_n=1. On the first ACK clock with wr_n=0, write mem[eff]<=cpu_dout and push the trace entry. Exactly one write/push per bus cycle.
  - ACK, strb=0: go to IDLE (clock-edge granularity). A new strobe needs at least one IDLE clock.
  - strb dropping during WAIT: go to IDLE, no write.
- Backdoor:
  - bd_we=1 writes mem[bd_addr]<=bd_wdata. bd_rdata<=mem[bd_addr] every clock (read-before-write).
  - Backdoor and CPU write to the same address in the same clock: the CPU write wins.
- Trace FIFO:
  - Push when the CPU write occurs and the FIFO is not full.
  - Pop when trace_valid & trace_ready.
  - Push on full: entry dropped, trace_ovf<=1 (sticky until reset). Pop on the same clock does not make room for that push.
  - Push and pop together when not full and not empty: count unchanged.
  - Push into an empty FIFO: trace_valid rises the next clock. Show-ahead head on trace_data.
  - Pointers wrap modulo TRACE_DEPTH.

Test Plan:
- Backdoor load 16'h2bd6<=8'hd3, read back -> bd_rdata=8'hd3 one clock later; tv80s running CB 9B from 0000 with E=64 -> PC=0002, E=64 (bit 3 already clear), trace stays empty.
- WAIT_CYCLES=2, CPU LD (2bd6),A with A=8'ha1 -> wait_n low exactly 2 clks; mem[2bd6]=a1; one trace entry {0,2bd6,a1}.
- OUT (45),A with A=8'h5c, IO_PAGE=10 -> mem[1045]=5c; trace {1,1045,5c}; mem[0045] unchanged.
- TRACE_DEPTH=4, 5 writes with trace_ready=0 -> 4 entries in order, trace_ovf=1. Pop all -> trace_valid=0 after the fourth pop; trace_ovf stays 1.
- Backdoor write 8'h11 and CPU write 8'h22 to 3000 in the same clock -> mem[3000]=22.
- Assert reset during WAIT of a write cycle -> no memory update, wait_n=1 immediately, FIFO empty, prior array data intact.
